// File: rtl/fir_pkg.sv
// Shared widths, defaults and state encodings for the FIR product accumulator
// and its rounding/saturation stage.
package fir_pkg;

   localparam int TAPS      = 8;
   localparam int ACC_W     = 35;
   localparam int OUT_SHIFT = 16;
   localparam int PROD_W    = 32;
   localparam int OUT_W     = 16;
   localparam int TAP_IDX_W = $clog2(TAPS);

   // y_valid doubles as the state bit: HOLD while a result waits downstream.
   localparam logic ST_ACCUM = 1'b0;
   localparam logic ST_HOLD  = 1'b1;

   function automatic logic [ACC_W-1:0] widen_prod(input logic [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){1'b0}}, p};
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, scale by OUT_SHIFT and clip an unsigned accumulator sum
// to a 16-bit output.
module fir_round_sat
   import fir_pkg::*;
(
   input  logic [ACC_W-1:0] sum,
   output logic [OUT_W-1:0] y,
   output logic             sat
);

   localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);

   logic [ACC_W:0] rounded;
   logic [ACC_W:0] shifted;

   // One extra bit so the rounding increment can never wrap a full sum.
   assign rounded = {1'b0, sum} + HALF;
   assign shifted = rounded >> OUT_SHIFT;
   assign sat     = |shifted[ACC_W:OUT_W];
   assign y       = sat ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

endmodule

// File: rtl/fir_mac_accumulator.sv
// Sums TAPS unsigned products per FIR output sample and presents the rounded,
// scaled, saturated result through a valid/ready output register.
module fir_mac_accumulator
   import fir_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 prod_valid,
   input  logic [PROD_W-1:0]    prod,
   output logic                 prod_ready,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic [OUT_W-1:0]     y,
   output logic                 y_sat,
   output logic [TAP_IDX_W-1:0] tap_idx
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic             accept;
   logic             last_tap;
   logic [OUT_W-1:0] y_calc;
   logic             sat_calc;

   assign prod_ready = (y_valid == ST_ACCUM) || y_ready;
   assign accept     = prod_valid && prod_ready && !clr;
   assign last_tap   = (tap_idx == TAP_IDX_W'(TAPS - 1));

   // The first tap of a frame loads rather than adds, so no clear cycle is needed.
   assign acc_next = (tap_idx == '0) ? widen_prod(prod) : acc + widen_prod(prod);

   fir_round_sat u_round_sat (
      .sum (acc_next),
      .y   (y_calc),
      .sat (sat_calc)
   );

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         tap_idx <= '0;
         y_valid <= ST_ACCUM;
         y       <= '0;
         y_sat   <= 1'b0;
      end else begin
         if (clr) begin
            acc     <= '0;
            tap_idx <= '0;
         end else if (accept) begin
            acc     <= acc_next;
            tap_idx <= last_tap ? '0 : tap_idx + 1'b1;
         end

         if (accept && last_tap) begin
            y_valid <= ST_HOLD;
            y       <= y_calc;
            y_sat   <= sat_calc;
         end else if (y_ready) begin
            y_valid <= ST_ACCUM;
         end
      end
   end

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Directed bench for fir_mac_accumulator: stimulus queues expected outputs,
// a negedge monitor pops and compares on every output handshake.
module tb_fir_mac_accumulator;
   import fir_pkg::*;

   typedef struct packed {
      logic [OUT_W-1:0] y;
      logic             sat;
   } exp_t;

   typedef logic [PROD_W-1:0] frame_t [TAPS];

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 clr = 1'b0;
   logic                 prod_valid = 1'b0;
   logic [PROD_W-1:0]    prod = '0;
   logic                 prod_ready;
   logic                 y_valid;
   logic                 y_ready = 1'b1;
   logic [OUT_W-1:0]     y;
   logic                 y_sat;
   logic [TAP_IDX_W-1:0] tap_idx;

   int   passed = 0;
   int   total  = 0;
   exp_t exp_q[$];

   fir_mac_accumulator dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_ready (prod_ready),
      .y_valid    (y_valid),
      .y_ready    (y_ready),
      .y          (y),
      .y_sat      (y_sat),
      .tap_idx    (tap_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic frame_t fill(input logic [PROD_W-1:0] v);
      frame_t f;
      for (int i = 0; i < TAPS; i++) f[i] = v;
      return f;
   endfunction

   // Present one product and hold it until the accepting edge has passed.
   task automatic send(input logic [PROD_W-1:0] p);
      int guard = 0;
      prod_valid = 1'b1;
      prod       = p;
      while (!prod_ready && guard < 200) begin
         step();
         guard++;
      end
      if (guard >= 200) check("send_timeout", 64'd1, 64'd0);
      step();
      prod_valid = 1'b0;
   endtask

   task automatic send_frame(input frame_t f, input logic [OUT_W-1:0] y_exp,
                             input logic sat_exp, input logic push);
      if (push) exp_q.push_back('{y: y_exp, sat: sat_exp});
      for (int i = 0; i < TAPS; i++) begin
         send(f[i]);
         if (i < TAPS - 1) check("tap_idx_count", 64'(tap_idx), 64'(i + 1));
      end
      check("y_valid_latency", 64'(y_valid), 64'd1);
      check("tap_idx_wrap", 64'(tap_idx), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_y_valid"}, 64'(y_valid), 64'd0);
      check({tag, "_y"}, 64'(y), 64'd0);
      check({tag, "_y_sat"}, 64'(y_sat), 64'd0);
      check({tag, "_tap_idx"}, 64'(tap_idx), 64'd0);
      check({tag, "_prod_ready"}, 64'(prod_ready), 64'd1);
   endtask

   // Monitor: every output handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && y_valid && y_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(y), 64'hDEAD);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("y_value", 64'(y), 64'(e.y));
            check("y_sat_flag", 64'(y_sat), 64'(e.sat));
         end
      end
   end

   initial begin
      frame_t f;

      repeat (3) step();
      rst = 1'b0;
      check_reset_state("reset");

      // Basic frame, with y_valid confirmed low before the final product.
      exp_q.push_back('{y: 16'd8, sat: 1'b0});
      for (int i = 0; i < TAPS - 1; i++) send(32'h0001_0000);
      check("y_valid_early", 64'(y_valid), 64'd0);
      send(32'h0001_0000);
      check("y_valid_latency", 64'(y_valid), 64'd1);

      // Rounding at the half-LSB boundary.
      f = fill(32'h0); f[TAPS-1] = 32'h0000_8000;
      send_frame(f, 16'd1, 1'b0, 1'b1);
      f = fill(32'h0); f[TAPS-1] = 32'h0000_7FFF;
      send_frame(f, 16'd0, 1'b0, 1'b1);

      // Mixed products: i * 0x11000, sum 0x264000 -> 38.
      for (int i = 0; i < TAPS; i++) f[i] = 32'(i + 1) * 32'h0001_1000;
      send_frame(f, 16'd38, 1'b0, 1'b1);

      // Saturation, then recovery proving the first tap reloads acc.
      send_frame(fill(32'hFFFF_FFFF), 16'hFFFF, 1'b1, 1'b1);
      send_frame(fill(32'h0001_0000), 16'd8, 1'b0, 1'b1);

      // Saturation threshold: 0xFFFF exactly vs first value that clips.
      f = fill(32'h0); f[TAPS-1] = 32'hFFFF_7FFF;
      send_frame(f, 16'hFFFF, 1'b0, 1'b1);
      f = fill(32'h0); f[TAPS-1] = 32'hFFFF_8000;
      send_frame(f, 16'hFFFF, 1'b1, 1'b1);

      // Back-pressure: stall with a product offered, then release.
      step();
      y_ready = 1'b0;
      send_frame(fill(32'h0001_0000), 16'd8, 1'b0, 1'b1);
      prod_valid = 1'b1;
      prod       = 32'h0003_0000;
      repeat (5) begin
         @(negedge clk);
         check("bp_prod_ready", 64'(prod_ready), 64'd0);
         check("bp_y_valid", 64'(y_valid), 64'd1);
         check("bp_y_stable", 64'(y), 64'd8);
         check("bp_tap_idx_hold", 64'(tap_idx), 64'd0);
      end
      step();
      prod_valid = 1'b0;
      y_ready    = 1'b1;
      #1;
      check("bp_release_ready", 64'(prod_ready), 64'd1);
      send_frame(fill(32'h0003_0000), 16'd24, 1'b0, 1'b1);

      // clr on tap 4 drops the offered product.
      for (int i = 0; i < 4; i++) send(32'h0005_0000);
      check("pre_clr_tap_idx", 64'(tap_idx), 64'd4);
      clr        = 1'b1;
      prod_valid = 1'b1;
      prod       = 32'h0005_0000;
      step();
      clr        = 1'b0;
      prod_valid = 1'b0;
      check("clr_tap_idx", 64'(tap_idx), 64'd0);
      send_frame(fill(32'h0002_0000), 16'd16, 1'b0, 1'b1);

      // rst at tap 5 with a product offered.
      step();
      for (int i = 0; i < 5; i++) send(32'h0001_0000);
      rst        = 1'b1;
      prod_valid = 1'b1;
      step();
      rst        = 1'b0;
      prod_valid = 1'b0;
      check_reset_state("rst_mid");
      send_frame(fill(32'h0004_0000), 16'd32, 1'b0, 1'b1);

      // rst while a result is pending: the pending result is discarded.
      step();
      y_ready = 1'b0;
      send_frame(fill(32'h0001_0000), 16'd8, 1'b0, 1'b0);
      check("pending_y", 64'(y), 64'd8);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("rst_hold");
      y_ready = 1'b1;
      send_frame(fill(32'h0000_C000), 16'd6, 1'b0, 1'b1);

      begin
         int guard = 0;
         while (exp_q.size() != 0 && guard < 50) begin
            step();
            guard++;
         end
      end
      check("outputs_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
